wave_req_sel: RTL

Parametrised request selector/handshaker between the per-logic request lines and the waveform engine. Selects one of `N_CH` request lines by `wave_sel` and converts rising edges on the selected line into a held `Wave_req` / `Wave_ack` handshake. Edges that arrive while busy are counted, so none are lost up to counter saturation. Channel switches take effect only when idle, followed by a guard window, so a switch never produces a false request.

---
 rtl/wave_req_sel.sv | 95 +++++++++
 1 files changed

// File: rtl/wave_req_sel.sv
// Request selector/handshaker: picks one request line by wave_sel and turns its
// rising edges into a held Wave_req/Wave_ack handshake, queueing edges seen while busy.
module wave_req_sel #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned SEL_W = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GUARD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] wave_sel,
  input  logic [N_CH-1:0]  Logics_req,
  input  logic             Wave_ack,
  output logic             Wave_req,
  output logic [SEL_W-1:0] cur_sel,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf,
  output logic             sel_err
);

  localparam int unsigned GCW = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GUARD
  } state_t;

  state_t         state;
  logic [GCW-1:0] gcnt;
  logic           s;
  logic           s_d;
  logic           rise;
  logic           sel_valid;

  // Compare-based mux keeps the select width independent of N_CH.
  always_comb begin
    s = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cur_sel == SEL_W'(i)) s = Logics_req[i];
    end
  end

  assign rise      = s & ~s_d;
  assign sel_valid = 32'(wave_sel) < N_CH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      gcnt     <= '0;
      s_d      <= 1'b0;
      Wave_req <= 1'b0;
      cur_sel  <= '0;
      pend_cnt <= '0;
      ovf      <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      s_d     <= s;
      sel_err <= ~sel_valid;
      case (state)
        S_IDLE: begin
          if (rise) begin
            state    <= S_REQ;
            Wave_req <= 1'b1;
          end else if (pend_cnt != '0) begin
            state    <= S_REQ;
            Wave_req <= 1'b1;
            pend_cnt <= pend_cnt - CNT_W'(1);
          end else if (sel_valid && (wave_sel != cur_sel)) begin
            state   <= S_GUARD;
            cur_sel <= wave_sel;
            gcnt    <= GCW'(GUARD - 1);
          end
        end
        S_REQ: begin
          if (rise) begin
            if (pend_cnt == '1) ovf <= 1'b1;
            else                pend_cnt <= pend_cnt + CNT_W'(1);
          end
          if (Wave_ack) begin
            Wave_req <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_GUARD: begin
          // Edges here are dropped; s_d still follows the newly selected line.
          if (gcnt == '0) state <= S_IDLE;
          else            gcnt  <= gcnt - GCW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
